// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing Y = A - B - BI (mod 2^WIDTH), one bit per
//   clock, LSB first. Operands are captured on an accepted start. Results are
//   loaded on the completion edge and held until the next completion.
//
//   Handshake: start is a request pulse that is honoured only in IDLE. Once a
//   request is taken, busy stays high through RUN and DONE, and further start
//   pulses are dropped (there is no queuing). done is high for exactly one
//   cycle, and during that cycle Y/BO/V already carry the new result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request pulse (accepted in IDLE only)
//   A, B       minuend / subtrahend, captured on accept
//   BI         borrow-in, captured on accept
//   Y          difference, WIDTH bits
//   BO         unsigned borrow-out (A < B + BI)
//   V          two's-complement overflow
//   busy       high in RUN and DONE
//   done       single-cycle completion strobe
//   state_dbg  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
//   WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic [WIDTH-1:0] Y,
  output logic             BO,
  output logic             V,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Wide enough to hold WIDTH, so the counter never wraps during RUN.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  // The shift registers lose their MSBs while shifting, so the sign bits are
  // kept aside for the overflow decision.
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             br_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;

  // One full-subtractor cell acting on the current LSBs.
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
    res_nxt  = {d, res_sr[WIDTH-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Y      <= '0;
      BO     <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= BI;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_nxt;
          res_sr <= res_nxt;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            Y  <= res_nxt;
            BO <= br_nxt;
            // Overflow only when the operand signs differ and the result
            // sign disagrees with the minuend; d is the result MSB here.
            V  <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH = 8). A driver issues
//   operations and pushes the reference result {Y, BO, V} into exp_q. A
//   separate monitor pops and compares whenever done is presented. The driver
//   also checks timing (busy/done per cycle), result holding, and reset.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic [W-1:0] Y;
  logic         BO;
  logic         V;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;
  int           n_cmp;
  int           n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .BI        (BI),
    .Y         (Y),
    .BO        (BO),
    .V         (V),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sb;
    int          sd;
    logic [W-1:0] y;
    logic         bo;
    logic         v;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    y  = W'(ua - ub - bi);
    bo = (ua < ub + bi);
    sd = sa - sb - bi;
    v  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return {y, bo, v};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending op at %0t", $time);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", {Y, BO, V}, e);
      end
    end
  end

  // ---------------- driver ----------------
  // Issue one op from IDLE; optionally pulse start with junk at edge `poke`
  // (0 = no poke). Checks busy/done each cycle and the done latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input int poke);
    check("hold_before", {Y, BO, V}, last_res);
    A = a;
    B = b;
    BI = bi;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, bi));
    #1;
    start = 1'b0;
    // Operands changing after capture must not matter.
    A = W'($urandom);
    B = W'($urandom);
    BI = 1'($urandom);
    check("busy_accept", {busy, done}, 2'b10);
    for (int e = 1; e <= W; e++) begin
      if (e == poke) begin
        start = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e < W) check("run_flags", {busy, done}, 2'b10);
      if (e == W / 2) check("hold_mid_run", {Y, BO, V}, last_res);
    end
    check("done_latency", {busy, done}, 2'b11);
    @(posedge clk);
    #1;
    check("done_single", {busy, done}, 2'b00);
    last_res = model(a, b, bi);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    last_res = '0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    BI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", {Y, BO, V}, '0);
    check("reset_flags", {busy, done}, 2'b00);
    check("reset_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_hold", {busy, done, Y}, '0);

    // Directed vectors.
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    run_op(8'h10, 8'h10, 1'b1, 0);
    run_op(8'h10, 8'h10, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h80, 8'h00, 1'b1, 0);

    // Start pulsed mid-run is ignored.
    run_op(8'h5A, 8'h3C, 1'b0, 3);

    // Start held high across DONE: ignored there, accepted at the next IDLE edge.
    A = 8'h5A;
    B = 8'h3C;
    BI = 1'b0;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
    #1;
    start = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("hold_done", {busy, done}, 2'b11);
    start = 1'b1;
    A = 8'h11;
    B = 8'h22;
    BI = 1'b0;
    @(posedge clk);
    #1;
    check("start_in_done_ignored", {busy, done}, 2'b00);
    @(posedge clk);
    exp_q.push_back(model(8'h11, 8'h22, 1'b0));
    #1;
    start = 1'b0;
    check("start_after_done", {busy, done}, 2'b10);
    repeat (W - 1) @(posedge clk);
    #1;
    check("held_run", {busy, done}, 2'b10);
    @(posedge clk);
    #1;
    check("held_done", {busy, done}, 2'b11);
    @(posedge clk);
    #1;
    check("held_idle", {busy, done}, 2'b00);
    last_res = model(8'h11, 8'h22, 1'b0);

    // Reset mid-run aborts with no done pulse.
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    A = 8'h5A;
    B = 8'h3C;
    BI = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", {busy, done}, 2'b10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_result", {Y, BO, V}, '0);
    check("abort_flags", {busy, done}, 2'b00);
    rst_n = 1'b1;
    last_res = '0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("no_done_after_abort", {busy, done}, 2'b00);
    run_op(8'h03, 8'h05, 1'b0, 0);

    // Randomized operations, some with a stray start during RUN.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W)));
    end

    @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 start  input  1  request pulse; accepted only in IDLE.
REQ-006 A  input  WIDTH  minuend, captured when start is accepted.
REQ-007 B  input  WIDTH  subtrahend, captured when start is accepted.
REQ-008 BI  input  1  borrow-in, captured when start is accepted.
REQ-009 Y  output  WIDTH  difference A - B - BI, mod 2^WIDTH.
REQ-010 BO  output  1  borrow-out; 1 when A < B + BI as unsigned values.
REQ-011 V  output  1  signed overflow of the two's-complement subtraction.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  single-cycle completion strobe.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE. IDLE is entered on reset.
REQ-015 IDLE: start=1 at a rising edge SHALL capture A, B and BI into shift registers, clear the bit counter and the result shift register, and enter RUN.
REQ-016 IDLE with start=0 SHALL hold the state and all outputs.
REQ-017 RUN: each edge SHALL process one bit, LSB first.
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
- br initialised to the captured BI
- d is shifted into the result MSB
- A and B shift registers shift right by one
- bit counter increments
REQ-018 RUN SHALL last exactly WIDTH edges. On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and, on that same edge, load Y, BO and V:
- Y = completed result
- BO = final br_next
- V = (A[MSB] != B[MSB]) && (Y[MSB] != A[MSB]), using the captured operands
REQ-019 Latency: if start is accepted at edge 0, done SHALL be high in the cycle after edge WIDTH, and only in that cycle.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 Y, BO and V SHALL change only on the completion edge (and on reset); they hold their value until the next completion.
REQ-022 start in RUN or DONE SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-023 A, B and BI changing after capture SHALL have no effect on the result.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.
REQ-025 BI=1 with A == B SHALL give Y = all ones and BO = 1.

Reset
REQ-026 rst_n=0 at any edge SHALL force the following, overriding start and any operation in flight:
- state = IDLE
- Y = 0, BO = 0, V = 0
- busy = 0, done = 0
- counter, shift registers and borrow register = 0
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse. After reset releases, the first start SHALL be accepted normally.

Verification
REQ-028 A=0x5A, B=0x3C, BI=0, start at edge 0 -> done high after edge 8, Y=0x1E, BO=0, V=0, busy high from edge 0 through the DONE cycle.
REQ-029 A=0x00, B=0x01, BI=0 -> Y=0xFF, BO=1, V=0.
REQ-030 A=0x80, B=0x01, BI=0 -> Y=0x7F, BO=0, V=1. Then A=0x7F, B=0xFF -> Y=0x80, BO=1, V=1.
REQ-031 A=0x10, B=0x10, BI=1 -> Y=0xFF, BO=1, V=0. Same operands with BI=0 -> Y=0x00, BO=0.
REQ-032 Run started with A=0x5A, B=0x3C. At edge 3 start is pulsed with A=0xFF, B=0x00 -> ignored, and the result is still 0x1E. A start held high through the DONE cycle is ignored there and accepted at the following IDLE edge.
REQ-033 Run started with prior Y=0x1E. rst_n=0 at edge 4 -> Y=0, BO=0, V=0, busy=0, no done pulse. After release, a new start with A=0x03, B=0x05 -> Y=0xFE, BO=1, done 8 edges after acceptance.
